// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_ctrl_pkg
// Description : Shared types, defaults and the round-robin pick helper used
//               by trigger_write_arbiter and other bus arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Arbiter sequencer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Widest requester vector any arbiter built on rr_pick may use
  localparam int unsigned MAX_REQ        = 8;
  localparam int unsigned DEF_NR_OF_BITS = 2;
  localparam int unsigned DEF_HOLD_LIMIT = 4;

  // One-hot winner: first set bit of req scanning ptr, ptr+1, ... modulo n.
  // Only the low n bits of req are considered; returns 0 if none set.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] pick;
    logic [31:0]        idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && req[idx[2:0]]) begin
          pick[idx[2:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin scan. Returns the one-hot index of
//               the first active request at or after the start pointer.
// Ports       : i_req   - N request bits
//               i_ptr   - round-robin start index (0..N-1)
//               o_grant - one-hot winner, 0 when no request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                      i_req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
  output logic [N-1:0]                      o_grant
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick_ext;

  assign w_req_ext  = MAX_REQ'(i_req);
  assign w_pick_ext = rr_pick(w_req_ext, 3'(i_ptr), N);
  assign o_grant    = w_pick_ext[N-1:0];

  // Bits above N are always zero; fold them so they are consumed.
  if (N < MAX_REQ) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = |w_pick_ext[MAX_REQ-1:N];
  end

endmodule
`default_nettype wire

// File: rtl/trigger_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : trigger_write_arbiter
// Description : Round-robin write arbiter/sequencer for a shared trigger
//               register with clock enable. Optional lock gives one
//               requester back-to-back writes, bounded by HOLD_LIMIT.
// Ports       : i_clock, i_reset  - clock, synchronous active-high reset
//               i_req, i_lock     - per-requester request / lock
//               i_data_in         - packed write data, requester i at [i*W +: W]
//               o_grant, o_ack    - one-hot owner / one-cycle write ack
//               o_reg_d, o_reg_ce - register D and clock enable
//               o_busy, o_timeout - in HOLD / HOLD ended by limit
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_write_arbiter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NR_OF_REQUESTERS = 4,
  parameter int unsigned NR_OF_BITS       = DEF_NR_OF_BITS,
  parameter int unsigned HOLD_LIMIT       = DEF_HOLD_LIMIT
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic [NR_OF_REQUESTERS-1:0]            i_req,
  input  logic [NR_OF_REQUESTERS-1:0]            i_lock,
  input  logic [NR_OF_REQUESTERS*NR_OF_BITS-1:0] i_data_in,
  output logic [NR_OF_REQUESTERS-1:0]            o_grant,
  output logic [NR_OF_REQUESTERS-1:0]            o_ack,
  output logic [NR_OF_BITS-1:0]                  o_reg_d,
  output logic                                   o_reg_ce,
  output logic                                   o_busy,
  output logic                                   o_timeout
);

  localparam int unsigned PTR_W = (NR_OF_REQUESTERS > 1) ? $clog2(NR_OF_REQUESTERS) : 1;
  localparam int unsigned HC_W  = $clog2(HOLD_LIMIT);
  localparam logic [HC_W-1:0]  C_HOLD_LAST = HC_W'(HOLD_LIMIT - 1);
  localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(NR_OF_REQUESTERS - 1);

  // Registered state
  state_t                        r_state;
  logic [PTR_W-1:0]              r_ptr;
  logic [HC_W-1:0]               r_hold_cnt;
  logic [NR_OF_REQUESTERS-1:0]   r_grant;
  logic [NR_OF_REQUESTERS-1:0]   r_ack;
  logic [NR_OF_BITS-1:0]         r_reg_d;
  logic                          r_reg_ce;
  logic                          r_busy;
  logic                          r_timeout;

  // Next-state values
  state_t                        w_state_nxt;
  logic [PTR_W-1:0]              w_ptr_nxt;
  logic [HC_W-1:0]               w_hold_cnt_nxt;
  logic [NR_OF_REQUESTERS-1:0]   w_grant_nxt;
  logic [NR_OF_REQUESTERS-1:0]   w_ack_nxt;
  logic [NR_OF_BITS-1:0]         w_reg_d_nxt;
  logic                          w_reg_ce_nxt;
  logic                          w_busy_nxt;
  logic                          w_timeout_nxt;

  // Arbitration helpers
  logic [NR_OF_REQUESTERS-1:0]   w_pick;
  logic [PTR_W-1:0]              w_win_idx;
  logic [NR_OF_BITS-1:0]         w_win_data;
  logic [NR_OF_BITS-1:0]         w_own_data;
  logic                          w_win_lock;
  logic                          w_own_lock;
  logic                          w_own_req;

  rr_priority_picker #(
    .N (NR_OF_REQUESTERS)
  ) u_picker (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // In HOLD r_grant is the owner's one-hot, so it doubles as the owner mask.
  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    w_own_data = '0;
    for (int unsigned i = 0; i < NR_OF_REQUESTERS; i++) begin
      if (w_pick[i]) begin
        w_win_idx  = PTR_W'(i);
        w_win_data = i_data_in[i*NR_OF_BITS +: NR_OF_BITS];
      end
      if (r_grant[i]) begin
        w_own_data = i_data_in[i*NR_OF_BITS +: NR_OF_BITS];
      end
    end
  end

  assign w_win_lock = |(w_pick & i_lock);
  assign w_own_lock = |(r_grant & i_lock);
  assign w_own_req  = |(r_grant & i_req);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    w_grant_nxt    = '0;
    w_ack_nxt      = '0;
    w_reg_d_nxt    = r_reg_d;
    w_reg_ce_nxt   = 1'b0;
    w_busy_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_pick) begin
          w_reg_d_nxt  = w_win_data;
          w_reg_ce_nxt = 1'b1;
          w_ack_nxt    = w_pick;
          w_grant_nxt  = w_pick;
          w_ptr_nxt    = (w_win_idx == C_PTR_LAST) ? '0 : w_win_idx + PTR_W'(1);
          if (w_win_lock) begin
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = '0;
            w_busy_nxt     = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!w_own_lock || (r_hold_cnt == C_HOLD_LAST)) begin
          // Release: one bubble cycle; timeout only if lock was still held
          w_state_nxt   = IDLE;
          w_timeout_nxt = w_own_lock;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
          w_grant_nxt    = r_grant;
          w_busy_nxt     = 1'b1;
          if (w_own_req) begin
            w_reg_d_nxt  = w_own_data;
            w_reg_ce_nxt = 1'b1;
            w_ack_nxt    = r_grant;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_reg_d    <= '0;
      r_reg_ce   <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_ack_nxt;
      r_reg_d    <= w_reg_d_nxt;
      r_reg_ce   <= w_reg_ce_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_ack     = r_ack;
  assign o_reg_d   = r_reg_d;
  assign o_reg_ce  = r_reg_ce;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_trigger_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_write_arbiter
// Description : Self-checking bench for trigger_write_arbiter: behavioural
//               reference compared every cycle plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int HL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N*W-1:0]   din;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [W-1:0]     regd;
  logic             ce;
  logic             busy;
  logic             tmo;

  int checks   = 0;
  int failures = 0;

  trigger_write_arbiter #(
    .NR_OF_REQUESTERS (N),
    .NR_OF_BITS       (W),
    .HOLD_LIMIT       (HL)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_req     (req),
    .i_lock    (lock),
    .i_data_in (din),
    .o_grant   (grant),
    .o_ack     (ack),
    .o_reg_d   (regd),
    .o_reg_ce  (ce),
    .o_busy    (busy),
    .o_timeout (tmo)
  );

  // Reference model: abstract state as plain integers
  int           m_ptr   = 0;
  int           m_cnt   = 0;
  int           m_owner = 0;
  bit           m_hold  = 1'b0;
  logic [N-1:0] e_grant = '0;
  logic [N-1:0] e_ack   = '0;
  logic [W-1:0] e_regd  = '0;
  logic         e_ce    = 1'b0;
  logic         e_busy  = 1'b0;
  logic         e_tmo   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] q,
                            input logic [N-1:0] lk, input logic [N*W-1:0] d);
    int w;
    if (r) begin
      m_hold = 1'b0; m_ptr = 0; m_cnt = 0; m_owner = 0;
      e_grant = '0; e_ack = '0; e_regd = '0; e_ce = 1'b0; e_busy = 1'b0; e_tmo = 1'b0;
      return;
    end
    e_grant = '0; e_ack = '0; e_ce = 1'b0; e_busy = 1'b0; e_tmo = 1'b0;
    if (!m_hold) begin
      w = first_from(q, m_ptr);
      if (w >= 0) begin
        e_regd  = d[w*W +: W];
        e_ce    = 1'b1;
        e_ack   = N'(1) << w;
        e_grant = e_ack;
        m_ptr   = (w + 1) % N;
        if (lk[w]) begin
          m_hold = 1'b1; m_owner = w; m_cnt = 0; e_busy = 1'b1;
        end
      end
    end else if (!lk[m_owner] || m_cnt == HL - 1) begin
      m_hold = 1'b0;
      e_tmo  = lk[m_owner];
    end else begin
      m_cnt++;
      e_grant = N'(1) << m_owner;
      e_busy  = 1'b1;
      if (q[m_owner]) begin
        e_regd = d[m_owner*W +: W];
        e_ce   = 1'b1;
        e_ack  = e_grant;
      end
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, req, lock, din);
      #1;
      chk("m_grant",   32'(grant), 32'(e_grant));
      chk("m_ack",     32'(ack),   32'(e_ack));
      chk("m_regd",    32'(regd),  32'(e_regd));
      chk("m_ce",      32'(ce),    32'(e_ce));
      chk("m_busy",    32'(busy),  32'(e_busy));
      chk("m_timeout", 32'(tmo),   32'(e_tmo));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [N-1:0] rr_seq [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    lock = '0;
    din  = {2'b00, 2'b10, 2'b01, 2'b11};   // req3=00 req2=10 req1=01 req0=11

    // Reset held two cycles with all requests active
    tick; tick;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_ce",    32'(ce),    32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_tmo",   32'(tmo),   32'h0);
    chk("rst_regd",  32'(regd),  32'h0);
    rst = 1'b0;
    tick;
    chk("first_ack",  32'(ack),  32'b0001);
    chk("first_regd", 32'(regd), 32'b11);

    // Two requesters from Ptr=0
    rst = 1'b1; req = '0; tick;
    rst = 1'b0; req = 4'b0110; tick;
    chk("s2_ack1",  32'(ack),  32'b0010);
    chk("s2_regd1", 32'(regd), 32'b01);
    tick;
    chk("s2_ack2",  32'(ack),  32'b0100);
    chk("s2_regd2", 32'(regd), 32'b10);
    chk("s2_mptr",  32'(m_ptr), 32'd3);
    req = '0; tick;
    chk("s2_idle_ce", 32'(ce), 32'h0);

    // All requesting, rotation continues from Ptr=3
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_ack", 32'(ack), 32'(rr_seq[i]));
      chk("rr_ce",  32'(ce),  32'h1);
    end

    // Lock held: HOLD ended by limit
    req = '0; rst = 1'b1; tick;
    rst = 1'b0; req = 4'b0011; lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("hl_ack",  32'(ack),  32'b0001);
      chk("hl_busy", 32'(busy), 32'h1);
    end
    tick;
    chk("hl_tmo",   32'(tmo),   32'h1);
    chk("hl_grant", 32'(grant), 32'h0);
    chk("hl_ce",    32'(ce),    32'h0);
    tick;
    chk("hl_next_ack", 32'(ack), 32'b0010);
    chk("hl_next_tmo", 32'(tmo), 32'h0);
    req = '0; lock = '0; tick;

    // Lock dropped after one HOLD cycle
    rst = 1'b1; tick;
    rst = 1'b0; req = 4'b0001; lock = 4'b0001; tick;
    chk("ld_ack1", 32'(ack), 32'b0001);
    tick;
    chk("ld_ack2", 32'(ack), 32'b0001);
    lock = '0; tick;
    chk("ld_tmo",   32'(tmo),   32'h0);
    chk("ld_ce",    32'(ce),    32'h0);
    chk("ld_busy",  32'(busy),  32'h0);
    chk("ld_grant", 32'(grant), 32'h0);
    req = '0; tick;

    // Reset in the middle of HOLD
    rst = 1'b1; tick;
    rst = 1'b0; req = 4'b0001; lock = 4'b0001; tick; tick;
    chk("rh_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1; tick;
    chk("rh_busy",  32'(busy),  32'h0);
    chk("rh_grant", 32'(grant), 32'h0);
    chk("rh_ce",    32'(ce),    32'h0);
    rst = 1'b0; req = 4'b1010; lock = '0; tick;
    chk("rh_ptr0_ack", 32'(ack), 32'b0010);
    req = '0; tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
